sdft_bin_reader: RTL and testbench

Host-side reader for the sliding-DFT bin read port. On a frame request it walks every frequency bin in order, drives the SDFT `read`/`bin_addr`/`ready` handshake, and captures each complex bin. It converts each bin to an approximate magnitude and streams the results downstream over a valid/ready interface. It sits between the SDFT core and whatever consumes the spectrum (display, UART packer).

---
 rtl/sdft_bin_reader.sv | 153 +++++++++++++++
 tb/tb_sdft_bin_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdft_bin_reader.sv
`default_nettype none
// ============================================================================
// Module   : sdft_bin_reader
// Brief    : Scans every SDFT bin, converts each one to max+min/2 magnitude
//            and streams it out over valid/ready. Optional peak tracker is
//            built when SDFT_READER_PEAK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sdft_bin_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FREQ_BINS  = 16,
    parameter int BIN_ADDR_W = $clog2(FREQ_BINS)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               frame_req,
    output logic                               busy,
    input  logic                               sdft_ready,
    output logic                               sdft_read,
    output logic [BIN_ADDR_W-1:0]              sdft_bin_addr,
    input  logic signed [DATA_WIDTH*2+3:0]     sdft_real,
    input  logic signed [DATA_WIDTH*2+3:0]     sdft_imag,
    output logic [DATA_WIDTH*2+3:0]            mag_data,
    output logic [BIN_ADDR_W-1:0]              mag_bin,
    output logic                               mag_last,
    output logic                               mag_valid,
    input  logic                               mag_ready,
    output logic [BIN_ADDR_W-1:0]              peak_bin,
    output logic [DATA_WIDTH*2+3:0]            peak_mag,
    output logic                               peak_valid
);

    localparam int c_bw = DATA_WIDTH * 2 + 4;
    localparam logic [BIN_ADDR_W-1:0] c_last_bin = BIN_ADDR_W'(FREQ_BINS - 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_issue     = 3'd1;
    localparam logic [2:0] c_st_wait_ack  = 3'd2;
    localparam logic [2:0] c_st_wait_data = 3'd3;
    localparam logic [2:0] c_st_calc      = 3'd4;
    localparam logic [2:0] c_st_output    = 3'd5;
    localparam logic [2:0] c_st_done      = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [BIN_ADDR_W-1:0] r_bin;
    logic [c_bw-1:0]       r_abs_re;
    logic [c_bw-1:0]       r_abs_im;
    logic [c_bw-1:0]       w_abs_re;
    logic [c_bw-1:0]       w_abs_im;
    logic [c_bw-1:0]       w_max;
    logic [c_bw-1:0]       w_min;
    logic [c_bw-1:0]       w_mag;
    logic                  w_start;
    logic                  w_hs;

    assign w_start       = (r_state == c_st_idle) && frame_req;
    assign w_hs          = (r_state == c_st_output) && mag_ready;
    assign sdft_bin_addr = r_bin;

    // Negating the most-negative value wraps to 2^(BW-1), which is the
    // correct unsigned magnitude.
    assign w_abs_re = sdft_real[c_bw-1] ? $unsigned(-sdft_real) : $unsigned(sdft_real);
    assign w_abs_im = sdft_imag[c_bw-1] ? $unsigned(-sdft_imag) : $unsigned(sdft_imag);
    assign w_max    = (r_abs_re >= r_abs_im) ? r_abs_re : r_abs_im;
    assign w_min    = (r_abs_re >= r_abs_im) ? r_abs_im : r_abs_re;
    assign w_mag    = w_max + (w_min >> 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:      if (frame_req)   w_next = c_st_issue;
            c_st_issue:     if (sdft_ready)  w_next = c_st_wait_ack;
            c_st_wait_ack:  if (!sdft_ready) w_next = c_st_wait_data;
            c_st_wait_data: if (sdft_ready)  w_next = c_st_calc;
            c_st_calc:                       w_next = c_st_output;
            c_st_output:    if (mag_ready)   w_next = mag_last ? c_st_done : c_st_issue;
            c_st_done:                       w_next = c_st_idle;
            default:                         w_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_st_idle);
        sdft_read  = (r_state == c_st_issue) && sdft_ready;
        mag_valid  = (r_state == c_st_output);
        peak_valid = 1'b0;
`ifdef SDFT_READER_PEAK_EN
        peak_valid = (r_state == c_st_done);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bin    <= '0;
            r_abs_re <= '0;
            r_abs_im <= '0;
            mag_data <= '0;
            mag_bin  <= '0;
            mag_last <= 1'b0;
        end else begin
            if (w_start) begin
                r_bin <= '0;
            end else if (w_hs && !mag_last) begin
                r_bin <= r_bin + 1'b1;
            end
            if ((r_state == c_st_wait_data) && sdft_ready) begin
                r_abs_re <= w_abs_re;
                r_abs_im <= w_abs_im;
            end
            if (r_state == c_st_calc) begin
                mag_data <= w_mag;
                mag_bin  <= r_bin;
                mag_last <= (r_bin == c_last_bin);
            end
        end
    end

`ifdef SDFT_READER_PEAK_EN
    logic [c_bw-1:0]       r_peak_mag;
    logic [BIN_ADDR_W-1:0] r_peak_bin;

    // Strictly-greater update keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_peak_mag <= '0;
            r_peak_bin <= '0;
        end else if (w_start) begin
            r_peak_mag <= '0;
            r_peak_bin <= '0;
        end else if (w_hs && (mag_data > r_peak_mag)) begin
            r_peak_mag <= mag_data;
            r_peak_bin <= mag_bin;
        end
    end

    assign peak_mag = r_peak_mag;
    assign peak_bin = r_peak_bin;
`else
    assign peak_mag = '0;
    assign peak_bin = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdft_bin_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdft_bin_reader
// Brief    : Directed, table-driven bench for sdft_bin_reader with a small
//            SDFT read-port model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdft_bin_reader;

    localparam int c_bw   = 20;
    localparam int c_bins = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              frame_req;
    logic              busy;
    logic              sdft_ready;
    logic              sdft_read;
    logic [3:0]        sdft_bin_addr;
    logic signed [c_bw-1:0] sdft_real;
    logic signed [c_bw-1:0] sdft_imag;
    logic [c_bw-1:0]   mag_data;
    logic [3:0]        mag_bin;
    logic              mag_last;
    logic              mag_valid;
    logic              mag_ready;
    logic [3:0]        peak_bin;
    logic [c_bw-1:0]   peak_mag;
    logic              peak_valid;

    sdft_bin_reader dut (
        .clk(clk), .reset_n(reset_n), .frame_req(frame_req), .busy(busy),
        .sdft_ready(sdft_ready), .sdft_read(sdft_read), .sdft_bin_addr(sdft_bin_addr),
        .sdft_real(sdft_real), .sdft_imag(sdft_imag),
        .mag_data(mag_data), .mag_bin(mag_bin), .mag_last(mag_last),
        .mag_valid(mag_valid), .mag_ready(mag_ready),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid)
    );

    always #5 clk = ~clk;

    // SDFT read-port model: ready drops the cycle after a read, returns
    // the cycle after that with the addressed bin on the data bus.
    logic signed [c_bw-1:0] mem_re [c_bins];
    logic signed [c_bw-1:0] mem_im [c_bins];
    logic                   m_ready;
    logic [3:0]             m_addr;
    logic                   hold;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_ready <= 1'b1;
            m_addr  <= '0;
        end else if (sdft_read) begin
            m_ready <= 1'b0;
            m_addr  <= sdft_bin_addr;
        end else if (!m_ready) begin
            m_ready <= 1'b1;
        end
    end

    assign sdft_ready = m_ready & ~hold;
    assign sdft_real  = mem_re[m_addr];
    assign sdft_imag  = mem_im[m_addr];

    typedef struct { int re; int im; int exp_mag; } vec_t;
    typedef struct { int bin; int data; int last; int cyc; } beat_t;

    vec_t  tbl [c_bins];
    beat_t beats [$];
    int    reads [$];
    int    peaks [$];
    int    cyc = 0;
    int    t0;
    int    idle_cyc;
    int    tests = 0;
    int    fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mag_valid && mag_ready)
            beats.push_back('{int'(mag_bin), int'(mag_data), int'(mag_last), cyc});
        if (sdft_read) reads.push_back(cyc);
        if (peak_valid) peaks.push_back(cyc);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {busy, sdft_read, sdft_bin_addr, mag_valid, mag_last, mag_bin,
                     mag_data, peak_valid, peak_bin, peak_mag}, 64'd0);
    endtask

    task automatic clear_mon();
        beats.delete();
        reads.delete();
        peaks.delete();
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        frame_req = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        frame_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        idle_cyc = cyc;
        check("idle timeout", busy, 0);
    endtask

    task automatic load_const(input int re, input int im);
        for (int i = 0; i < c_bins; i++) begin
            mem_re[i] = c_bw'(re);
            mem_im[i] = c_bw'(im);
        end
    endtask

    initial begin
        int n;
        int bad;
        logic [c_bw-1:0] d0;
        logic [3:0]      b0;

        tbl[0]  = '{0, 0, 0};
        tbl[1]  = '{1, 0, 1};
        tbl[2]  = '{3, -4, 5};
        tbl[3]  = '{-524288, -524288, 786432};
        tbl[4]  = '{524287, 0, 524287};
        tbl[5]  = '{-1, -1, 1};
        tbl[6]  = '{7, 7, 10};
        tbl[7]  = '{-10, 4, 12};
        tbl[8]  = '{4, -10, 12};
        tbl[9]  = '{100, -50, 125};
        tbl[10] = '{-524288, 524287, 786431};
        tbl[11] = '{0, -524288, 524288};
        tbl[12] = '{0, 1, 1};
        tbl[13] = '{2, 3, 4};
        tbl[14] = '{-6, -9, 12};
        tbl[15] = '{300000, 300000, 450000};

        reset_n = 1'b0; frame_req = 1'b0; mag_ready = 1'b1; hold = 1'b0;
        load_const(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset outputs");
        reset_n = 1'b1;

        // Table frame: every bin a different magnitude case, free-running timing.
        for (int i = 0; i < c_bins; i++) begin
            mem_re[i] = c_bw'(tbl[i].re);
            mem_im[i] = c_bw'(tbl[i].im);
        end
        clear_mon();
        start_frame();
        wait_idle();
        check("table beat count", beats.size(), 16);
        check("table read count", reads.size(), 16);
        check("table busy low cycle", idle_cyc - t0, 82);
        for (int i = 0; i < beats.size() && i < c_bins; i++) begin
            check($sformatf("bin%0d mag_bin", i), beats[i].bin, i);
            check($sformatf("bin%0d mag_data", i), beats[i].data, tbl[i].exp_mag);
            check($sformatf("bin%0d mag_last", i), beats[i].last, (i == c_bins - 1));
            check($sformatf("bin%0d valid cycle", i), beats[i].cyc - t0, 5 * i + 5);
        end
        for (int i = 0; i < reads.size() && i < c_bins; i++)
            check($sformatf("bin%0d read cycle", i), reads[i] - t0, 5 * i + 1);
`ifdef SDFT_READER_PEAK_EN
        check("table peak_bin", peak_bin, 3);
        check("table peak_mag", peak_mag, 786432);
        check("table peak pulses", peaks.size(), 1);
`else
        check("table peak tied off", {peak_bin, peak_mag}, 0);
        check("table peak pulses", peaks.size(), 0);
`endif

        // Output backpressure on bin 0.
        mag_ready = 1'b0;
        clear_mon();
        start_frame();
        n = 0;
        while (!mag_valid && n < 100) begin @(negedge clk); n++; end
        check("stall reach output", mag_valid, 1);
        d0 = mag_data; b0 = mag_bin;
        check("stall bin", b0, 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!mag_valid || mag_data !== d0 || mag_bin !== b0 || sdft_read) bad++;
        end
        check("stall hold cycles bad", bad, 0);
        check("stall read count", reads.size(), 1);
        mag_ready = 1'b1;
        wait_idle();
        check("stall beat count", beats.size(), 16);

        // SDFT not ready for 20 cycles after request.
        hold = 1'b1;
        clear_mon();
        start_frame();
        repeat (20) @(negedge clk);
        check("hold reads", reads.size(), 0);
        @(posedge clk); #1;
        hold = 1'b0;
        @(negedge clk);
        check("hold release read", sdft_read, 1);
        check("hold release addr", sdft_bin_addr, 0);
        wait_idle();
        check("hold beat count", beats.size(), 16);

        // Second request mid-frame is ignored.
        clear_mon();
        start_frame();
        while (cyc != t0 + 30) begin @(posedge clk); #1; end
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        wait_idle();
        check("ignored req beat count", beats.size(), 16);
        check("ignored req busy low cycle", idle_cyc - t0, 82);
        repeat (3) @(negedge clk);
        check("ignored req not queued", busy, 0);

        // Reset after bin 5 handshake, then restart.
        clear_mon();
        start_frame();
        n = 0;
        while (!(mag_valid && mag_ready && mag_bin == 4'd5) && n < 200) begin
            @(negedge clk); n++;
        end
        check("reach bin5", mag_bin, 5);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outs("midframe reset outputs");
        reset_n = 1'b1;
        clear_mon();
        start_frame();
        wait_idle();
        check("restart beat count", beats.size(), 16);
        if (beats.size() > 0) check("restart first bin", beats[0].bin, 0);
        if (reads.size() > 0) check("restart first read", reads[0] - t0, 1);

        // Peak tracking with a tie between bins 3 and 7.
        load_const(50, 0);
        mem_re[3] = -20'sd100;
        mem_re[7] = -20'sd100;
        clear_mon();
        start_frame();
        wait_idle();
        if (beats.size() > 7) begin
            check("peak frame bin3 mag", beats[3].data, 100);
            check("peak frame bin0 mag", beats[0].data, 50);
        end
`ifdef SDFT_READER_PEAK_EN
        check("peak_bin", peak_bin, 3);
        check("peak_mag", peak_mag, 100);
        check("peak pulse count", peaks.size(), 1);
        if (peaks.size() > 0) check("peak pulse cycle", peaks[0] - t0, 81);
`else
        check("peak tied off", {peak_bin, peak_mag}, 0);
        check("peak pulse count", peaks.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
